timer_arbiter: RTL

Shares a single loadable countdown counter among NUM_REQ requesters that each need a cycle-accurate delay or timeout. A requester raises its request with a length. The block grants the counter round-robin, counts the length down on qualified tick cycles, and returns a one-cycle done pulse to the winner. It sits between the free-running tick/threshold counters and the control FSMs that need timed waits, so those FSMs do not each carry a private counter.

---
 rtl/timer_arbiter_pkg.sv | 17 +
 rtl/timer_arbiter_rr_arbiter.sv | 29 ++
 rtl/timer_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/timer_arbiter_pkg.sv
// Shared types and helpers for the timer arbiter.
package timer_arbiter_pkg;

  localparam int unsigned MAX_REQ = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One-hot vector with bit idx set, sized for the largest supported requester count.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
    onehot = MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/timer_arbiter_rr_arbiter.sv
// Round-robin pick: first set request bit searching upward from last+1, wrapping.
module rr_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  // Scan NUM_REQ positions starting just after the previous winner.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last) + k) % NUM_REQ;
      if (!valid && ((req & NUM_REQ'(onehot(idx))) != '0)) begin
        winner = IDX_W'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Shared loadable countdown timer granted round-robin among NUM_REQ requesters.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           tick_en,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*CNT_WIDTH-1:0]   req_len,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic [CNT_WIDTH-1:0]           count
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       cur_q, cur_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [NUM_REQ-1:0]     grant_d, done_d;
  logic                   busy_d;
  logic [CNT_WIDTH-1:0]   count_d;
  logic [IDX_W-1:0]       win;
  logic                   win_valid;
  logic [CNT_WIDTH-1:0]   win_len;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req    (req),
    .last   (last_q),
    .winner (win),
    .valid  (win_valid)
  );

  // Length field of the current arbitration winner.
  always_comb begin
    win_len = CNT_WIDTH'(req_len >> (32'(win) * CNT_WIDTH));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    grant_d = grant;
    done_d  = '0;
    count_d = count;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          cur_d   = win;
          count_d = win_len;
          grant_d = NUM_REQ'(onehot(32'(win)));
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // grant is onehot(cur_q) throughout RUN, so it doubles as the winner mask.
        if ((req & grant) == '0) begin
          grant_d = '0;
          last_d  = cur_q;
          state_d = ST_IDLE;
        end else if (count == '0) begin
          grant_d = '0;
          done_d  = NUM_REQ'(onehot(32'(cur_q)));
          last_d  = cur_q;
          state_d = ST_DONE;
        end else if (tick_en) begin
          count_d = count - CNT_WIDTH'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
      count   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      grant   <= grant_d;
      done    <= done_d;
      busy    <= busy_d;
      count   <= count_d;
    end
  end

endmodule
